scroll_sequencer: RTL and testbench

Run/pause/step controller for the message scrolling datapath. It turns the free-running per-clock scroll into a rate-controlled, user-driven sequence. It owns the message position (`scroll_index`) and direction (`scroll_dir`), and issues a one-cycle `step_pulse` each time the visible window moves. It sits between the debounced button/switch front end and the character-window logic that drives the six 7-segment displays.

---
 rtl/scroll_sequencer_if.sv | 29 ++
 rtl/scroll_sequencer.sv | 132 +++++++++++++
 tb/tb_scroll_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/scroll_sequencer_if.sv
// Command/status bundle between the button front end (master) and the scroll sequencer (slave).
// The field widths follow MSG_LEN.
interface scroll_sequencer_if #(
    parameter int MSG_LEN = 11
) ();
    localparam int IW = $clog2(MSG_LEN);

    logic          start;
    logic          stop;
    logic          clear;
    logic          step_req;
    logic          dir_req;
    logic [1:0]    speed_sel;
    logic [IW-1:0] scroll_index;
    logic          scroll_dir;
    logic          step_pulse;
    logic          wrap_pulse;
    logic [1:0]    state;

    modport master (
        output start, stop, clear, step_req, dir_req, speed_sel,
        input  scroll_index, scroll_dir, step_pulse, wrap_pulse, state
    );

    modport slave (
        input  start, stop, clear, step_req, dir_req, speed_sel,
        output scroll_index, scroll_dir, step_pulse, wrap_pulse, state
    );
endinterface

// File: rtl/scroll_sequencer.sv
// Run/pause/step controller for the message scroll: all outputs are registered, one edge of command latency, no backpressure.
// Optional SCROLL_SEQ_ONESHOT_EN: a wrapping step taken in RUN ends the pass and returns to IDLE at index 0.
module scroll_sequencer #(
    parameter int MSG_LEN  = 11,
    parameter int BASE_DIV = 12_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    scroll_sequencer_if.slave   sif
);
    localparam int IW = $clog2(MSG_LEN);
    localparam int PW = $clog2((BASE_DIV << 3) + 1);
    localparam logic [PW-1:0] BASE_P = PW'(BASE_DIV);
    localparam logic [IW-1:0] LAST   = IW'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic [PW-1:0] presc_q, presc_d;

    logic [PW-1:0] period_m1;
    logic [IW-1:0] nxt_idx;
    logic          nxt_wrap;
    logic          take_step;

    assign period_m1 = (BASE_P << sif.speed_sel) - PW'(1);

    // Candidate position for a step taken on this edge, using the live direction request.
    always_comb begin
        if (sif.dir_req) begin
            nxt_wrap = (idx_q == '0);
            nxt_idx  = nxt_wrap ? LAST : idx_q - IW'(1);
        end else begin
            nxt_wrap = (idx_q == LAST);
            nxt_idx  = nxt_wrap ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        take_step = 1'b0;

        if (sif.clear) begin
            state_d = S_IDLE;
            idx_d   = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    // A stop on the same edge as a due step wins and the step is dropped.
                    if (sif.stop) begin
                        state_d = S_PAUSE;
                        presc_d = '0;
                    end else if (presc_q >= period_m1) begin
                        take_step = 1'b1;
                        presc_d   = '0;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    dir_d   = sif.dir_req;
                    presc_d = '0;
                    if (!sif.stop) begin
                        if (sif.start) begin
                            state_d = S_RUN;
                        end else if (sif.step_req) begin
                            take_step = 1'b1;
                        end
                    end
                end
                default: begin
                    dir_d   = sif.dir_req;
                    presc_d = '0;
                    if (sif.start) begin
                        state_d = S_RUN;
                    end
                end
            endcase
        end

        if (take_step) begin
            idx_d  = nxt_idx;
            dir_d  = sif.dir_req;
            step_d = 1'b1;
            wrap_d = nxt_wrap;
`ifdef SCROLL_SEQ_ONESHOT_EN
            if (state_q == S_RUN && nxt_wrap) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            presc_q <= presc_d;
        end
    end

    assign sif.scroll_index = idx_q;
    assign sif.scroll_dir   = dir_q;
    assign sif.step_pulse   = step_q;
    assign sif.wrap_pulse   = wrap_q;
    assign sif.state        = state_q;
endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer with MSG_LEN=11, BASE_DIV=4 (period 4 << speed_sel).
// A vector table covers idle/run/pause/priority behaviour; hand sequences cover the full pass and async reset.
module tb_scroll_sequencer;
    localparam int MSG_LEN  = 11;
    localparam int BASE_DIV = 4;
`ifdef SCROLL_SEQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_START = 4'b1000;
    localparam logic [3:0] C_STOP  = 4'b0100;
    localparam logic [3:0] C_CLEAR = 4'b0010;
    localparam logic [3:0] C_STEP  = 4'b0001;

    typedef struct {
        int         n;
        logic [3:0] cmd;
        logic       dir;
        logic [1:0] spd;
        int         idx;
        int         edir;
        int         stp;
        int         wrp;
        int         st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    scroll_sequencer_if #(.MSG_LEN(MSG_LEN)) sif ();

    scroll_sequencer #(.MSG_LEN(MSG_LEN), .BASE_DIV(BASE_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic set_cmd(input logic [3:0] c);
        {sif.start, sif.stop, sif.clear, sif.step_req} = c;
    endtask

    task automatic chk_all(input string tag, input int idx, input int dir,
                           input int stp, input int wrp, input int st);
        chk({tag, ".idx"},   int'(sif.scroll_index), idx);
        chk({tag, ".dir"},   int'(sif.scroll_dir),   dir);
        chk({tag, ".step"},  int'(sif.step_pulse),   stp);
        chk({tag, ".wrap"},  int'(sif.wrap_pulse),   wrp);
        chk({tag, ".state"}, int'(sif.state),        st);
    endtask

    vec_t tv[27];

    initial begin
        tv[0]  = '{19, C_NONE,           1'b0, 2'd0,  0, 0, 0, 0, 0};
        tv[1]  = '{0,  C_STOP,           1'b0, 2'd0,  0, 0, 0, 0, 0};
        tv[2]  = '{0,  C_STEP,           1'b0, 2'd0,  0, 0, 0, 0, 0};
        tv[3]  = '{0,  C_NONE,           1'b1, 2'd0,  0, 1, 0, 0, 0};
        tv[4]  = '{0,  C_START,          1'b0, 2'd0,  0, 0, 0, 0, 1};
        tv[5]  = '{2,  C_NONE,           1'b0, 2'd0,  0, 0, 0, 0, 1};
        tv[6]  = '{0,  C_NONE,           1'b0, 2'd0,  1, 0, 1, 0, 1};
        tv[7]  = '{3,  C_NONE,           1'b1, 2'd0,  0, 1, 1, 0, 1};
        tv[8]  = '{3,  C_NONE,           1'b1, 2'd0, 10, 1, 1, 1, 1};
        tv[9]  = '{0,  C_NONE,           1'b0, 2'd0, 10, 1, 0, 0, 1};
        tv[10] = '{0,  C_STOP,           1'b0, 2'd0, 10, 1, 0, 0, 2};
        tv[11] = '{49, C_NONE,           1'b0, 2'd0, 10, 0, 0, 0, 2};
        tv[12] = '{0,  C_STEP,           1'b0, 2'd0,  0, 0, 1, 1, 2};
        tv[13] = '{0,  C_NONE,           1'b0, 2'd0,  0, 0, 0, 0, 2};
        tv[14] = '{0,  C_STEP,           1'b0, 2'd0,  1, 0, 1, 0, 2};
        tv[15] = '{0,  C_START,          1'b0, 2'd0,  1, 0, 0, 0, 1};
        tv[16] = '{2,  C_NONE,           1'b0, 2'd0,  1, 0, 0, 0, 1};
        tv[17] = '{0,  C_NONE,           1'b0, 2'd0,  2, 0, 1, 0, 1};
        tv[18] = '{2,  C_NONE,           1'b0, 2'd0,  2, 0, 0, 0, 1};
        tv[19] = '{0,  C_START | C_STOP, 1'b0, 2'd0,  2, 0, 0, 0, 2};
        tv[20] = '{0,  C_START | C_STEP, 1'b0, 2'd0,  2, 0, 0, 0, 1};
        tv[21] = '{0,  C_CLEAR | C_START,1'b0, 2'd0,  0, 0, 0, 0, 0};
        tv[22] = '{0,  C_START,          1'b0, 2'd3,  0, 0, 0, 0, 1};
        tv[23] = '{9,  C_NONE,           1'b0, 2'd3,  0, 0, 0, 0, 1};
        tv[24] = '{0,  C_NONE,           1'b0, 2'd0,  1, 0, 1, 0, 1};
        tv[25] = '{3,  C_NONE,           1'b0, 2'd0,  2, 0, 1, 0, 1};
        tv[26] = '{0,  C_CLEAR,          1'b0, 2'd0,  0, 0, 0, 0, 0};

        set_cmd(C_NONE);
        sif.dir_req   = 1'b0;
        sif.speed_sel = 2'd0;

        // Values while reset is held.
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        if (!ONESHOT) begin
            for (int r = 0; r < 27; r++) begin
                sif.dir_req   = tv[r].dir;
                sif.speed_sel = tv[r].spd;
                set_cmd(C_NONE);
                repeat (tv[r].n) tick();
                set_cmd(tv[r].cmd);
                tick();
                set_cmd(C_NONE);
                chk_all($sformatf("vec%0d", r), tv[r].idx, tv[r].edir,
                        tv[r].stp, tv[r].wrp, tv[r].st);
            end
        end

        // Full pass from index 0: a step every 4 edges, wrap only on the 11th step.
        sif.dir_req   = 1'b0;
        sif.speed_sel = 2'd0;
        set_cmd(C_CLEAR);
        tick();
        set_cmd(C_START);
        tick();
        set_cmd(C_NONE);
        for (int k = 1; k <= 44; k++) begin
            tick();
            chk($sformatf("pass%0d.idx", k),  int'(sif.scroll_index), (k / 4) % MSG_LEN);
            chk($sformatf("pass%0d.step", k), int'(sif.step_pulse),   (k % 4 == 0) ? 1 : 0);
            chk($sformatf("pass%0d.wrap", k), int'(sif.wrap_pulse),   (k == 44) ? 1 : 0);
            chk($sformatf("pass%0d.state", k), int'(sif.state),
                (ONESHOT && k == 44) ? 0 : 1);
        end

        // Asynchronous reset in the middle of a RUN cycle.
        set_cmd(C_CLEAR);
        tick();
        set_cmd(C_START);
        tick();
        set_cmd(C_NONE);
        repeat (8) tick();
        chk_all("prerst", 2, 0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        chk_all("postrst", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
